mont_redc_stage: RTL and testbench

- Word-serial Montgomery reduction stage directly downstream of the 256x256 partial-product multiplier.
- Consumes the multiplier's 512-bit product T and returns T*R^-1 mod M, where R = 2^N.
- The modular multiplier top pairs it with the product stage to form a complete Montgomery modmul.
- Iterative, one result in flight, valid/ready handshake on both sides.

---
 rtl/mont_redc_stage.sv | 122 ++++++++++++
 tb/tb_mont_redc_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mont_redc_stage.sv
// Word-serial Montgomery reduction: out_data = T * 2^-N mod modulus, one result in flight.
// Define MONT_REDC_QPIPE_EN to split each iteration into a q cycle and an accumulate cycle.
module mont_redc_stage #(
   parameter int unsigned N    = 256,
   parameter int unsigned WORD = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   T,
   input  logic [N-1:0]     modulus,
   input  logic [WORD-1:0]  m_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data
);

   localparam int unsigned NW = N / WORD;
   localparam int unsigned CW = $clog2(NW + 1);
   localparam int unsigned AW = 2 * N + 1;
   localparam logic [CW-1:0] LastCnt = CW'(NW - 1);

   typedef enum logic [1:0] {StIdle, StIter, StFinal, StDone} state_e;

   state_e          state_q;
   logic [AW-1:0]   a_q;
   logic [N-1:0]    m_q;
   logic [WORD-1:0] minv_q;
   logic [CW-1:0]   cnt_q;
`ifdef MONT_REDC_QPIPE_EN
   logic [WORD-1:0] q_q;
   logic            phase_q;
`endif

   logic [WORD-1:0]   q_c;
   logic [WORD-1:0]   q_use;
   logic [N+WORD-1:0] qm;
   logic [AW:0]       sum;
   logic [AW-1:0]     a_next;
   logic              a_ge_m;
   logic [N-1:0]      fin;

   assign in_ready = (state_q == StIdle);

   always_comb begin
      q_c = a_q[WORD-1:0] * minv_q;
`ifdef MONT_REDC_QPIPE_EN
      q_use = q_q;
`else
      q_use = q_c;
`endif
      qm = {{N{1'b0}}, q_use} * {{WORD{1'b0}}, m_q};
      // One spare bit above A so the add never wraps before the shift.
      sum    = {1'b0, a_q} + {{(AW + 1 - N - WORD){1'b0}}, qm};
      a_next = AW'(sum >> WORD);
      a_ge_m = a_q >= {{(AW - N){1'b0}}, m_q};
      // A < 2M here, so the low N bits of A - M are the exact difference.
      fin    = a_ge_m ? (a_q[N-1:0] - m_q) : a_q[N-1:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         a_q       <= '0;
         m_q       <= '0;
         minv_q    <= '0;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
`ifdef MONT_REDC_QPIPE_EN
         q_q       <= '0;
         phase_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q     <= {1'b0, T};
                  m_q     <= modulus;
                  minv_q  <= m_inv;
                  cnt_q   <= '0;
                  state_q <= StIter;
`ifdef MONT_REDC_QPIPE_EN
                  phase_q <= 1'b0;
`endif
               end
            end
            StIter: begin
`ifdef MONT_REDC_QPIPE_EN
               if (!phase_q) begin
                  q_q     <= q_c;
                  phase_q <= 1'b1;
               end else begin
                  phase_q <= 1'b0;
                  a_q     <= a_next;
                  cnt_q   <= cnt_q + CW'(1);
                  if (cnt_q == LastCnt) state_q <= StFinal;
               end
`else
               a_q   <= a_next;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LastCnt) state_q <= StFinal;
`endif
            end
            StFinal: begin
               out_data  <= fin;
               out_valid <= 1'b1;
               state_q   <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_redc_stage.sv
// Directed and randomised bench for mont_redc_stage against a bit-serial REDC reference.
module tb_mont_redc_stage;

   localparam int N    = 256;
   localparam int WORD = 64;
`ifdef MONT_REDC_QPIPE_EN
   localparam int LAT = 9;
`else
   localparam int LAT = 5;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [2*N-1:0]   T = '0;
   logic [N-1:0]     modulus = '0;
   logic [WORD-1:0]  m_inv = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [N-1:0]     out_data;

   int checks = 0;
   int failures = 0;

   mont_redc_stage #(.N(N), .WORD(WORD)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .T         (T),
      .modulus   (modulus),
      .m_inv     (m_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [N-1:0] rand_n();
      logic [N-1:0] r;
      for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // -M^-1 mod 2^64 by Newton iteration on the low word.
   function automatic logic [WORD-1:0] calc_minv(input logic [WORD-1:0] m0);
      logic [WORD-1:0] x;
      x = m0;
      for (int i = 0; i < 6; i++) x = x * (64'd2 - m0 * x);
      return 64'd0 - x;
   endfunction

   // Bit-at-a-time REDC: N halvings, adding M whenever A is odd.
   function automatic logic [N-1:0] ref_redc(input logic [2*N-1:0] t, input logic [N-1:0] m);
      logic [2*N:0] a;
      logic [2*N:0] mx;
      a  = {1'b0, t};
      mx = {{(N+1){1'b0}}, m};
      for (int i = 0; i < N; i++) begin
         if (a[0]) a = a + mx;
         a = a >> 1;
      end
      if (a >= mx) a = a - mx;
      return a[N-1:0];
   endfunction

   // Issue one operation with out_ready high; returns the result after checking timing.
   task automatic run_op(input logic [2*N-1:0] t, input logic [N-1:0] m,
                         input logic [WORD-1:0] mi, output logic [N-1:0] res);
      int lat;
      chk_bit("in_ready_before_accept", in_ready, 1'b1);
      T = t; modulus = m; m_inv = mi; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      T = ~t; modulus = ~m; m_inv = ~mi;
      lat = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
      chk_int("latency", lat, LAT);
      chk_bit("in_ready_in_done", in_ready, 1'b0);
      res = out_data;
      step();
      chk_bit("out_valid_drop", out_valid, 1'b0);
      chk_bit("in_ready_after_done", in_ready, 1'b1);
   endtask

   logic [N-1:0]   m0;
   logic [WORD-1:0] mi0;
   logic [N-1:0]   res;
   logic [N-1:0]   held;
   logic [N-1:0]   rm;
   logic [N-1:0]   hi;
   logic [2*N-1:0] rt;
   logic           seen;
   int             lat;

   initial begin
      m0  = (256'd1 << 255) | 256'd1;
      mi0 = 64'hFFFF_FFFF_FFFF_FFFF;

      // Reset values
      #12;
      chk_bit("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_data", out_data, '0);
      reset = 1'b1;
      step();
      chk_bit("reset_in_ready", in_ready, 1'b1);
      chk_int("minv_calc", int'(calc_minv(64'd1) == mi0), 1);

      // Directed vectors
      run_op('0, m0, mi0, res);
      chk("t_zero", res, '0);
      run_op({256'd5, 256'd0}, m0, mi0, res);
      chk("t_5R", res, 256'd5);
      run_op({m0 - 256'd1, 256'd0}, m0, mi0, res);
      chk("t_mm1R", res, m0 - 256'd1);
      run_op({256'd0, m0}, m0, mi0, res);
      chk("t_eq_m", res, '0);

      // Backpressure: result held, inputs ignored while DONE
      out_ready = 1'b0;
      T = {256'd5, 256'd0}; modulus = m0; m_inv = mi0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         step();
         lat++;
      end
      chk_int("bp_latency", lat, LAT);
      held = out_data;
      chk("bp_data", held, 256'd5);
      for (int i = 0; i < 4; i++) begin
         chk_bit("bp_valid_held", out_valid, 1'b1);
         chk("bp_data_held", out_data, held);
         chk_bit("bp_in_ready_low", in_ready, 1'b0);
         in_valid = (i % 2 == 0);
         T = {256'd7, 256'd0};
         step();
      end
      out_ready = 1'b1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk_bit("bp_release_valid", out_valid, 1'b0);
      chk_bit("bp_release_ready", in_ready, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk_bit("bp_no_phantom", seen, 1'b0);
      chk("bp_data_after", out_data, 256'd5);

      // Reset mid-iteration aborts the operation
      T = {256'd9, 256'd0}; modulus = m0; m_inv = mi0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      #2 reset = 1'b0;
      #1;
      chk_bit("abort_out_valid", out_valid, 1'b0);
      chk("abort_out_data", out_data, '0);
      @(negedge clock);
      reset = 1'b1;
      step();
      chk_bit("abort_in_ready", in_ready, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      chk_bit("abort_no_result", seen, 1'b0);

      // Random operands against the reference model
      for (int i = 0; i < 1000; i++) begin
         rm = rand_n() | 256'd1;
         if (i % 3 == 0) rm[N-1] = 1'b1;
         hi = (i % 4 == 0) ? rm - 256'd1 : rand_n() % rm;
         rt = (i % 7 == 0) ? {256'd0, rm} : {hi, rand_n()};
         run_op(rt, rm, calc_minv(rm[WORD-1:0]), res);
         chk("rand_result", res, ref_redc(rt, rm));
         chk_bit("rand_lt_m", res < rm, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
